// File: rtl/midi_in_parser.sv
// midi_in_parser
//   Receives a raw MIDI serial stream (8N1, idle high), reassembles bytes and
//   decodes channel voice messages into a monophonic note/velocity/gate
//   interface suitable for driving a note-to-frequency table.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        serial bit rate (31250 for MIDI)
//
// Ports
//   clk         system clock, all state changes on its rising edge
//   rst_n       asynchronous active-low reset
//   midi_in     raw serial line, asynchronous to clk
//   channel     MIDI channel to accept (0-15)
//   omni        1 = accept every channel
//   rx_byte     last correctly framed byte
//   rx_valid    one-cycle pulse when rx_byte updates
//   frame_err   one-cycle pulse when a stop bit is sampled low
//   midi_note   current note number
//   velocity    velocity of the current note
//   gate        high while the current note is held
//   note_strobe one-cycle pulse on each accepted note-on
module midi_in_parser #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 31250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_in,
  input  logic [3:0] channel,
  input  logic       omni,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [6:0] midi_note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       note_strobe
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(BIT_CYC + 1);

  localparam logic [CW-1:0] HALF_LD = CW'(BIT_CYC / 2);
  // Counting down from BIT_CYC-1 to zero and sampling on the zero cycle gives
  // exactly BIT_CYC clocks between consecutive samples.
  localparam logic [CW-1:0] FULL_LD = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_NOSTAT,
    P_WAIT_D1,
    P_WAIT_D2
  } p_state_t;

  // ---------------------------------------------------------------------
  // Input synchronizer plus one extra stage used for falling-edge detection
  // ---------------------------------------------------------------------
  logic sync1, sync2, line_prev;
  logic rx_line;

  assign rx_line = sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= midi_in;
      sync2     <= sync1;
      line_prev <= sync2;
    end
  end

  // ---------------------------------------------------------------------
  // Serial receiver
  // ---------------------------------------------------------------------
  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shift, shift_nx;
  logic [7:0]    rx_byte_nx;
  logic          rx_valid_nx, frame_err_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_idx_nx;
      shift     <= shift_nx;
      rx_byte   <= rx_byte_nx;
      rx_valid  <= rx_valid_nx;
      frame_err <= frame_err_nx;
    end
  end

  // A start is recognised only on a high-to-low transition. After a framing
  // error the line may still be low, and after a reset released mid-byte the
  // line may be anywhere inside a character; neither must be mistaken for a
  // new start bit.
  always_comb begin
    rx_state_nx  = rx_state;
    cnt_nx       = cnt;
    bit_idx_nx   = bit_idx;
    shift_nx     = shift;
    rx_byte_nx   = rx_byte;
    rx_valid_nx  = 1'b0;
    frame_err_nx = 1'b0;

    case (rx_state)
      RX_IDLE: begin
        if (!rx_line && line_prev) begin
          rx_state_nx = RX_START;
          cnt_nx      = HALF_LD;
        end
      end

      RX_START: begin
        if (cnt != '0) begin
          cnt_nx = cnt - ONE;
        end else if (!rx_line) begin
          rx_state_nx = RX_DATA;
          cnt_nx      = FULL_LD;
          bit_idx_nx  = '0;
        end else begin
          rx_state_nx = RX_IDLE;
        end
      end

      RX_DATA: begin
        if (cnt != '0) begin
          cnt_nx = cnt - ONE;
        end else begin
          shift_nx   = {rx_line, shift[7:1]};
          cnt_nx     = FULL_LD;
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            rx_state_nx = RX_STOP;
          end
        end
      end

      RX_STOP: begin
        if (cnt != '0) begin
          cnt_nx = cnt - ONE;
        end else begin
          rx_state_nx = RX_IDLE;
          if (rx_line) begin
            rx_byte_nx  = shift;
            rx_valid_nx = 1'b1;
          end else begin
            frame_err_nx = 1'b1;
          end
        end
      end

      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Message parser
  // ---------------------------------------------------------------------
  p_state_t   p_state, p_state_nx;
  logic [7:0] run_status, run_status_nx;
  logic [6:0] data1, data1_nx;
  logic [6:0] midi_note_nx, velocity_nx;
  logic       gate_nx, note_strobe_nx;

  logic [3:0] msg_type;
  logic       one_data;
  logic       chan_match;

  assign msg_type   = run_status[7:4];
  assign one_data   = (msg_type == 4'hC) || (msg_type == 4'hD);
  assign chan_match = omni || (run_status[3:0] == channel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state     <= P_NOSTAT;
      run_status  <= '0;
      data1       <= '0;
      midi_note   <= '0;
      velocity    <= '0;
      gate        <= 1'b0;
      note_strobe <= 1'b0;
    end else begin
      p_state     <= p_state_nx;
      run_status  <= run_status_nx;
      data1       <= data1_nx;
      midi_note   <= midi_note_nx;
      velocity    <= velocity_nx;
      gate        <= gate_nx;
      note_strobe <= note_strobe_nx;
    end
  end

  // Realtime bytes (F8-FF) may be interleaved anywhere, so they fall through
  // without touching the parser. A status byte always restarts message
  // collection, which also abandons any half-received message.
  always_comb begin
    p_state_nx     = p_state;
    run_status_nx  = run_status;
    data1_nx       = data1;
    midi_note_nx   = midi_note;
    velocity_nx    = velocity;
    gate_nx        = gate;
    note_strobe_nx = 1'b0;

    if (rx_valid) begin
      if (rx_byte[7]) begin
        if (rx_byte[7:3] != 5'b11111) begin
          if (rx_byte[7:4] == 4'hF) begin
            run_status_nx = '0;
            p_state_nx    = P_NOSTAT;
          end else begin
            run_status_nx = rx_byte;
            p_state_nx    = P_WAIT_D1;
          end
        end
      end else begin
        case (p_state)
          P_WAIT_D1: begin
            // Program change / channel pressure complete with one byte and
            // carry no note information; stay put for running status.
            if (!one_data) begin
              data1_nx   = rx_byte[6:0];
              p_state_nx = P_WAIT_D2;
            end
          end

          P_WAIT_D2: begin
            p_state_nx = P_WAIT_D1;
            if (chan_match) begin
              if ((msg_type == 4'h9) && (rx_byte[6:0] != 7'd0)) begin
                midi_note_nx   = data1;
                velocity_nx    = rx_byte[6:0];
                gate_nx        = 1'b1;
                note_strobe_nx = 1'b1;
              end else if ((msg_type == 4'h8) || (msg_type == 4'h9)) begin
                // Releasing an older note must not cut the one now sounding.
                if (data1 == midi_note) begin
                  gate_nx = 1'b0;
                end
              end
            end
          end

          default: p_state_nx = p_state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_in_parser.sv
// tb_midi_in_parser
//   Directed self-checking bench for midi_in_parser at 32 clocks per bit.
//   Bytes are driven serially on midi_in; a monitor counts output pulses and
//   each scenario task compares outputs against hand-computed values.
module tb_midi_in_parser;

  localparam int BIT = 32;

  logic       clk;
  logic       rst_n;
  logic       midi_in;
  logic [3:0] channel;
  logic       omni;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic [6:0] midi_note;
  logic [6:0] velocity;
  logic       gate;
  logic       note_strobe;

  int vectors;
  int miscompares;
  int rv_total;
  int fe_total;
  int ns_total;
  logic [7:0] last_rx;

  midi_in_parser #(
    .CLK_FREQ(1000000),
    .BAUD    (31250)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .midi_in    (midi_in),
    .channel    (channel),
    .omni       (omni),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .midi_note  (midi_note),
    .velocity   (velocity),
    .gate       (gate),
    .note_strobe(note_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rv_total = rv_total + 1;
        last_rx  = rx_byte;
      end
      if (frame_err)   fe_total = fe_total + 1;
      if (note_strobe) ns_total = ns_total + 1;
    end
  end

  // Drives one 8N1 character starting at a falling clock edge
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    midi_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_in = b[i];
      repeat (BIT) @(negedge clk);
    end
    midi_in = stop_bit;
    repeat (BIT) @(negedge clk);
    midi_in = 1'b1;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    midi_in = 1'b1;
    channel = 4'd0;
    omni    = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if ({rx_byte, rx_valid, frame_err} !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL reset.rx: got %h, expected 0", {rx_byte, rx_valid, frame_err});
    end
    vectors++;
    if ({midi_note, velocity, gate, note_strobe} !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset.note: got %h, expected 0", {midi_note, velocity, gate, note_strobe});
    end
    rst_n = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    vectors++;
    if (rv_total !== 0 || fe_total !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset.idle_quiet: got rv=%0d fe=%0d, expected 0 0", rv_total, fe_total);
    end
  endtask

  task automatic test_note_on;
    int rv0, ns0;
    rv0 = rv_total;
    ns0 = ns_total;
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    vectors++;
    if (rv_total - rv0 !== 3) begin
      miscompares++;
      $display("[TB] FAIL note_on.rx_count: got %0d, expected 3", rv_total - rv0);
    end
    vectors++;
    if (rx_byte !== 8'h64) begin
      miscompares++;
      $display("[TB] FAIL note_on.rx_byte: got %h, expected 64", rx_byte);
    end
    vectors++;
    if (midi_note !== 7'd60 || velocity !== 7'd100 || gate !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL note_on.outputs: got note=%0d vel=%0d gate=%b, expected 60 100 1", midi_note, velocity, gate);
    end
    vectors++;
    if (ns_total - ns0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL note_on.strobe: got %0d, expected 1", ns_total - ns0);
    end
  endtask

  task automatic test_running_status;
    int ns0;
    ns0 = ns_total;
    send_byte(8'h3E, 1'b1);
    send_byte(8'h50, 1'b1);
    vectors++;
    if (midi_note !== 7'd62 || velocity !== 7'd80 || gate !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL running.note_on: got note=%0d vel=%0d gate=%b, expected 62 80 1", midi_note, velocity, gate);
    end
    vectors++;
    if (ns_total - ns0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL running.strobe: got %0d, expected 1", ns_total - ns0);
    end
    send_byte(8'h3C, 1'b1);
    send_byte(8'h00, 1'b1);
    vectors++;
    if (gate !== 1'b1 || midi_note !== 7'd62) begin
      miscompares++;
      $display("[TB] FAIL running.other_off: got gate=%b note=%0d, expected 1 62", gate, midi_note);
    end
    send_byte(8'h3E, 1'b1);
    send_byte(8'h00, 1'b1);
    vectors++;
    if (gate !== 1'b0 || midi_note !== 7'd62 || velocity !== 7'd80) begin
      miscompares++;
      $display("[TB] FAIL running.own_off: got gate=%b note=%0d vel=%0d, expected 0 62 80", gate, midi_note, velocity);
    end
    vectors++;
    if (ns_total - ns0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL running.no_strobe_on_off: got %0d, expected 1", ns_total - ns0);
    end
  endtask

  task automatic test_omni;
    int ns0;
    ns0 = ns_total;
    send_byte(8'h91, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h7F, 1'b1);
    vectors++;
    if (midi_note !== 7'd62 || velocity !== 7'd80 || gate !== 1'b0 || ns_total !== ns0) begin
      miscompares++;
      $display("[TB] FAIL omni.other_channel: got note=%0d vel=%0d gate=%b strobes=%0d, expected 62 80 0 0",
               midi_note, velocity, gate, ns_total - ns0);
    end
    omni = 1'b1;
    send_byte(8'h91, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h7F, 1'b1);
    vectors++;
    if (midi_note !== 7'd64 || velocity !== 7'd127 || gate !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL omni.accept: got note=%0d vel=%0d gate=%b, expected 64 127 1", midi_note, velocity, gate);
    end
    vectors++;
    if (ns_total - ns0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL omni.strobe: got %0d, expected 1", ns_total - ns0);
    end
    omni = 1'b0;
  endtask

  task automatic test_realtime;
    int rv0, ns0;
    rv0 = rv_total;
    ns0 = ns_total;
    send_byte(8'h90, 1'b1);
    send_byte(8'hF8, 1'b1);
    send_byte(8'h45, 1'b1);
    send_byte(8'hFE, 1'b1);
    send_byte(8'h70, 1'b1);
    vectors++;
    if (midi_note !== 7'd69 || velocity !== 7'd112 || gate !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL realtime.note: got note=%0d vel=%0d gate=%b, expected 69 112 1", midi_note, velocity, gate);
    end
    vectors++;
    if (rv_total - rv0 !== 5 || last_rx !== 8'h70) begin
      miscompares++;
      $display("[TB] FAIL realtime.rx: got count=%0d last=%h, expected 5 70", rv_total - rv0, last_rx);
    end
    vectors++;
    if (ns_total - ns0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL realtime.strobe: got %0d, expected 1", ns_total - ns0);
    end
  endtask

  task automatic test_frame_error;
    int rv0, fe0;
    rv0 = rv_total;
    fe0 = fe_total;
    send_byte(8'h55, 1'b0);
    repeat (BIT) @(negedge clk);
    vectors++;
    if (fe_total - fe0 !== 1 || rv_total !== rv0) begin
      miscompares++;
      $display("[TB] FAIL frame.err_pulse: got fe=%0d rv=%0d, expected 1 0", fe_total - fe0, rv_total - rv0);
    end
    vectors++;
    if (rx_byte !== 8'h70 || midi_note !== 7'd69 || gate !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL frame.hold: got rx=%h note=%0d gate=%b, expected 70 69 1", rx_byte, midi_note, gate);
    end
    fe0 = fe_total;
    midi_in = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    midi_in = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    vectors++;
    if (fe_total !== fe0 || rv_total !== rv0) begin
      miscompares++;
      $display("[TB] FAIL frame.glitch: got fe=%0d rv=%0d, expected 0 0", fe_total - fe0, rv_total - rv0);
    end
  endtask

  task automatic test_reset_mid_byte;
    logic [7:0] b;
    int ns0;
    send_byte(8'h90, 1'b1);
    b = 8'h3C;
    midi_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      midi_in = b[i];
      repeat (BIT) @(negedge clk);
    end
    midi_in = b[4];
    repeat (BIT / 2) @(negedge clk);
    rst_n   = 1'b0;
    midi_in = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rx_byte, rx_valid, frame_err, midi_note, velocity, gate, note_strobe} !== 26'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset.outputs: got %h, expected 0",
               {rx_byte, rx_valid, frame_err, midi_note, velocity, gate, note_strobe});
    end
    repeat (2 * BIT) @(negedge clk);
    rst_n = 1'b1;
    repeat (BIT) @(negedge clk);
    ns0 = ns_total;
    send_byte(8'h90, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h10, 1'b1);
    vectors++;
    if (midi_note !== 7'd48 || velocity !== 7'd16 || gate !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset.resume: got note=%0d vel=%0d gate=%b, expected 48 16 1", midi_note, velocity, gate);
    end
    vectors++;
    if (ns_total - ns0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL midreset.strobe: got %0d, expected 1", ns_total - ns0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rv_total    = 0;
    fe_total    = 0;
    ns_total    = 0;
    last_rx     = 8'h00;
    rst_n       = 1'b0;
    midi_in     = 1'b1;
    channel     = 4'd0;
    omni        = 1'b0;
    @(negedge clk);
    test_reset();
    test_note_on();
    test_running_status();
    test_omni();
    test_realtime();
    test_frame_error();
    test_reset_mid_byte();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
